main_mem_responder: RTL and testbench
=====================================

Name: main_mem_responder

Overview:
Clocked main-memory slave for the cache-to-memory interface: accepts one word read/write request from the cache miss/write-back path and answers after a fixed access latency with a one-cycle done pulse. It also hosts the page table, answering virtual-to-physical page lookups for the TLB refill path. It sits below the cache/TLB pair and replaces the zero-latency behavioural memory model.

Parameters:
LATENCY, 4, cycles from request acceptance to mem_done (legal range 1..15)
ADDR_W, 10, byte address width of the data port
DATA_W, 32, word width
VPN_W, 6, virtual page number width
PPN_W, 2, physical page number width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
mem_req  input  1  request strobe; sampled only in IDLE
r_w_type_mem  input  1  0 = read, 1 = write; sampled with mem_req
addr_bus  input  ADDR_W  byte address; bits [1:0] ignored, word index = addr_bus[9:2]
write_bus  input  DATA_W  write data; sampled with mem_req
read_bus  output  DATA_W  read data; valid while mem_done=1, held afterwards
mem_done  output  1  one-cycle completion pulse (reads and writes)
busy  output  1  high from acceptance until the edge that leaves DONE
pt_req  input  1  page-table lookup strobe
virtual_page_number  input  VPN_W  page to translate; sampled with pt_req
physical_page_number  output  PPN_W  translation result
page_hit  output  1  1 = page mapped, 0 = page fault
pt_done  output  1  one-cycle lookup completion pulse

Behaviour:
- Storage: 256 x DATA_W word array. Simulation initial content: word[i] = i, zero-extended. Reset does not clear the array.
- Page table: 2^VPN_W entries of {valid, ppn}. Reset loads VPN 0..3 valid with ppn = VPN; all other entries are invalid.
- Reset values: state IDLE, latency counter 0, read_bus 0, mem_done 0, busy 0, physical_page_number 0, page_hit 0, pt_done 0.
- Data FSM states:
  - IDLE: on mem_req=1, latch r_w_type_mem, word index and write_bus; load the counter with LATENCY-1; set busy=1; go to ACCESS.
  - ACCESS: while the counter is nonzero, decrement it. When the counter is 0:
    - Read: read_bus <= word[idx].
    - Write: word[idx] <= latched data; read_bus is unchanged.
    - In both cases mem_done <= 1 and the FSM goes to DONE.
  - DONE: mem_done <= 0, busy <= 0, go to IDLE. mem_req is ignored in this cycle.
- Timing: for a request accepted at edge E0, mem_done is high during the cycle after edge E_LATENCY, exactly one cycle wide. The earliest next acceptance is edge E_LATENCY+2.
- Inputs are latched at acceptance, so changes to addr/data/rw while busy have no effect.
- Read after write to the same word returns the new data.
- The counter is 4 bits wide. LATENCY=1 enters ACCESS with counter 0, so mem_done follows one edge after acceptance.
- Reset mid-operation: the pending write is not performed, mem_done stays 0, and the FSM returns to IDLE on that edge.
- Page-table path is independent of the data FSM and may overlap it:
  - pt_req=1 at edge E: at E, physical_page_number <= entry.ppn and page_hit <= entry.valid; pt_done=1 for the one cycle following E.
  - Invalid entry: page_hit=0 and physical_page_number=0.
  - Back-to-back pt_req on consecutive cycles is legal, giving one result per cycle.
  - pt_done=0 in any cycle after an edge where pt_req=0.

Test Plan:
- Reset, then read addr 0x014 (word 5), LATENCY=4 -> busy high, mem_done high exactly 4 cycles after acceptance for 1 cycle, read_bus=0x00000005.
- Write 0x00114514 to addr 0x26C, then read addr 0x26C -> write mem_done pulse with read_bus unchanged; read returns 0x00114514.
- mem_req held high continuously, with addr changed mid-access -> the first request completes using the latched address; the second is accepted only 2 edges after the first mem_done edge.
- Assert reset 2 cycles into a write of 0x1919 to 0x32C, then read 0x32C -> no mem_done, returns 0x000000CB.
- Lookups for VPN 1, VPN 7, VPN 3 on consecutive cycles -> pt_done high 3 cycles with (page_hit, ppn) = (1,1), (0,0), (1,3).
- Page lookup issued during an outstanding data read -> both complete with correct values; data latency unaffected.

Source files
------------

// File: rtl/main_mem_responder_if.sv
// Cache-side bus into main memory: word data port plus page-table lookup port.
// The master is the cache/TLB side; the slave is the memory responder.
interface main_mem_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int VPN_W  = 6,
  parameter int PPN_W  = 2
);
  logic              mem_req;
  logic              r_w_type_mem;
  logic [ADDR_W-1:0] addr_bus;
  logic [DATA_W-1:0] write_bus;
  logic [DATA_W-1:0] read_bus;
  logic              mem_done;
  logic              busy;
  logic              pt_req;
  logic [VPN_W-1:0]  virtual_page_number;
  logic [PPN_W-1:0]  physical_page_number;
  logic              page_hit;
  logic              pt_done;

  modport master (
    output mem_req, r_w_type_mem, addr_bus, write_bus, pt_req, virtual_page_number,
    input  read_bus, mem_done, busy, physical_page_number, page_hit, pt_done
  );

  modport slave (
    input  mem_req, r_w_type_mem, addr_bus, write_bus, pt_req, virtual_page_number,
    output read_bus, mem_done, busy, physical_page_number, page_hit, pt_done
  );
endinterface

// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory slave with a one-cycle page-table lookup port.
//   state     | meaning
//   ST_IDLE   | waiting for mem_req; request fields latched on acceptance
//   ST_ACCESS | latency countdown; access performed when the counter is 0
//   ST_DONE   | mem_done high for this cycle; busy drops on the exit edge
module main_mem_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int VPN_W   = 6,
  parameter int PPN_W   = 2
) (
  input logic clk,
  input logic reset,
  main_mem_responder_if.slave bus
);
  localparam int WORDS      = 256;
  localparam int IDX_W      = 8;
  localparam int PT_ENTRIES = 2 ** VPN_W;
  localparam int PT_MAPPED  = 4;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("main_mem_responder: LATENCY must be within 1..15");
  end

  typedef logic [DATA_W-1:0] mem_t [WORDS];

  function automatic mem_t mem_image();
    mem_t img;
    for (int i = 0; i < WORDS; i++) img[i] = DATA_W'(i);
    return img;
  endfunction

  // Power-up image: every word holds its own index. Reset never touches it.
  mem_t mem_q = mem_image();

  logic [1:0]        state_q;
  logic [3:0]        cnt_q;
  logic              rw_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] read_q;
  logic              done_q;
  logic              busy_q;
  logic              access_now;

  logic              pt_valid_q [PT_ENTRIES];
  logic [PPN_W-1:0]  pt_ppn_q   [PT_ENTRIES];
  logic [PPN_W-1:0]  ppn_q;
  logic              hit_q;
  logic              pt_done_q;

  logic              addr_unused;
  assign addr_unused = ^bus.addr_bus[1:0];

  assign access_now = (state_q == ST_ACCESS) && (cnt_q == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      read_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.mem_req) begin
            rw_q    <= bus.r_w_type_mem;
            idx_q   <= bus.addr_bus[IDX_W+1:2];
            wdata_q <= bus.write_bus;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!rw_q) read_q <= mem_q[idx_q];
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Gated by reset so a write interrupted by reset on its final edge is dropped.
  always_ff @(posedge clk) begin
    if (!reset && access_now && rw_q) mem_q[idx_q] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PT_ENTRIES; i++) begin
        pt_valid_q[i] <= (i < PT_MAPPED);
        pt_ppn_q[i]   <= (i < PT_MAPPED) ? PPN_W'(i) : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ppn_q     <= '0;
      hit_q     <= 1'b0;
      pt_done_q <= 1'b0;
    end else begin
      pt_done_q <= bus.pt_req;
      if (bus.pt_req) begin
        hit_q <= pt_valid_q[bus.virtual_page_number];
        ppn_q <= pt_valid_q[bus.virtual_page_number] ?
                 pt_ppn_q[bus.virtual_page_number] : '0;
      end
    end
  end

  assign bus.read_bus             = read_q;
  assign bus.mem_done             = done_q;
  assign bus.busy                 = busy_q;
  assign bus.physical_page_number = ppn_q;
  assign bus.page_hit             = hit_q;
  assign bus.pt_done              = pt_done_q;
endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: edge-scheduled reference model checked every
// cycle, plus hand-computed pinned values at key points of the directed flow.
module tb_main_mem_responder;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  main_mem_responder_if #(.ADDR_W(10), .DATA_W(32), .VPN_W(6), .PPN_W(2)) bus ();

  main_mem_responder #(
    .LATENCY(LAT), .ADDR_W(10), .DATA_W(32), .VPN_W(6), .PPN_W(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Reference model: request timing by edge arithmetic, memory as a plain array
  logic [31:0] model_mem [256];
  bit          mm_init = 0;
  int          edge_n = 0;
  int          acc_edge = -100, done_edge = -100, next_acc = 0;
  logic        m_rw = 1'b0;
  int          m_idx = 0;
  logic [31:0] m_wdata = '0;
  logic [31:0] exp_read = '0;
  logic        exp_done = 1'b0, exp_busy = 1'b0;
  logic        exp_pt_done = 1'b0, exp_hit = 1'b0;
  logic [1:0]  exp_ppn = '0;

  always @(posedge clk) begin
    if (!mm_init) begin
      for (int i = 0; i < 256; i++) model_mem[i] = 32'(i);
      mm_init = 1;
    end
    edge_n++;
    if (reset) begin
      acc_edge = -100; done_edge = -100; next_acc = edge_n + 1;
      exp_read = '0; exp_pt_done = 1'b0; exp_hit = 1'b0; exp_ppn = '0;
    end else begin
      if (edge_n == done_edge) begin
        if (m_rw) model_mem[m_idx] = m_wdata;
        else      exp_read = model_mem[m_idx];
      end
      if (bus.mem_req && edge_n >= next_acc) begin
        acc_edge  = edge_n;
        done_edge = edge_n + LAT;
        next_acc  = edge_n + LAT + 2;
        m_rw      = bus.r_w_type_mem;
        m_idx     = int'(bus.addr_bus) / 4;
        m_wdata   = bus.write_bus;
      end
      exp_pt_done = bus.pt_req;
      if (bus.pt_req) begin
        exp_hit = (bus.virtual_page_number < 6'd4);
        exp_ppn = exp_hit ? bus.virtual_page_number[1:0] : 2'd0;
      end
    end
    exp_done = !reset && (edge_n == done_edge);
    exp_busy = (edge_n >= acc_edge) && (edge_n <= done_edge);
  end

  // Pinned literal expectations, posted by the stimulus, checked by the compare process
  bit          chk_en = 0;
  logic [33:0] pin_d_exp = '0;
  string       pin_d_name = "";
  int          pin_d_seq = 0;
  logic [3:0]  pin_p_exp = '0;
  string       pin_p_name = "";
  int          pin_p_seq = 0;

  int n_checks = 0;
  int n_fail   = 0;
  int pin_d_seen = 0;
  int pin_p_seen = 0;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_done", 34'(bus.mem_done), 34'(exp_done));
      chk("busy", 34'(bus.busy), 34'(exp_busy));
      chk("read_bus", 34'(bus.read_bus), 34'(exp_read));
      chk("pt_done", 34'(bus.pt_done), 34'(exp_pt_done));
      chk("page_hit", 34'(bus.page_hit), 34'(exp_hit));
      chk("ppn", 34'(bus.physical_page_number), 34'(exp_ppn));
      if (pin_d_seq != pin_d_seen) begin
        pin_d_seen = pin_d_seq;
        chk(pin_d_name, {bus.mem_done, bus.busy, bus.read_bus}, pin_d_exp);
      end
      if (pin_p_seq != pin_p_seen) begin
        pin_p_seen = pin_p_seq;
        chk(pin_p_name, 34'({bus.pt_done, bus.page_hit, bus.physical_page_number}),
            34'(pin_p_exp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pin_d(input string name, input logic [33:0] exp);
    pin_d_name = name; pin_d_exp = exp; pin_d_seq++;
  endtask

  task automatic pin_p(input string name, input logic [3:0] exp);
    pin_p_name = name; pin_p_exp = exp; pin_p_seq++;
  endtask

  // Bounded wait; on timeout the following pinned check sees mem_done=0 and fails
  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.mem_done && n < 20);
  endtask

  task automatic issue(input logic rw, input logic [9:0] addr, input logic [31:0] data);
    bus.mem_req = 1'b1; bus.r_w_type_mem = rw; bus.addr_bus = addr; bus.write_bus = data;
    step();
    bus.mem_req = 1'b0;
  endtask

  int n;

  initial begin
    bus.mem_req = 1'b0; bus.r_w_type_mem = 1'b0; bus.addr_bus = '0; bus.write_bus = '0;
    bus.pt_req = 1'b0; bus.virtual_page_number = '0;
    step();
    chk_en = 1;
    pin_d("reset_data", 34'h0);
    pin_p("reset_pt", 4'h0);
    step();
    reset = 1'b0;
    step();

    issue(1'b0, 10'h014, 32'h0);
    pin_d("rd_accept", {1'b0, 1'b1, 32'h0});
    wait_done(n);
    pin_d("rd_word5", {1'b1, 1'b1, 32'h0000_0005});
    step();
    pin_d("rd_idle", {1'b0, 1'b0, 32'h0000_0005});

    issue(1'b1, 10'h26C, 32'h0011_4514);
    wait_done(n);
    pin_d("wr_done", {1'b1, 1'b1, 32'h0000_0005});
    step();
    issue(1'b0, 10'h26C, 32'h0);
    wait_done(n);
    pin_d("raw_read", {1'b1, 1'b1, 32'h0011_4514});
    step();

    bus.mem_req = 1'b1; bus.r_w_type_mem = 1'b0; bus.addr_bus = 10'h008;
    step();
    bus.addr_bus = 10'h00C;
    wait_done(n);
    pin_d("held_first", {1'b1, 1'b1, 32'h0000_0002});
    wait_done(n);
    pin_d("held_second", {1'b1, 1'b1, 32'h0000_0003});
    bus.mem_req = 1'b0;
    step();

    issue(1'b1, 10'h32C, 32'h0000_1919);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    pin_d("mid_reset", 34'h0);
    repeat (6) step();
    issue(1'b0, 10'h32C, 32'h0);
    wait_done(n);
    pin_d("rst_read", {1'b1, 1'b1, 32'h0000_00CB});
    step();

    bus.pt_req = 1'b1; bus.virtual_page_number = 6'd1;
    step();
    pin_p("vpn1", 4'b1101);
    bus.virtual_page_number = 6'd7;
    step();
    pin_p("vpn7", 4'b1000);
    bus.virtual_page_number = 6'd3;
    step();
    pin_p("vpn3", 4'b1111);
    bus.pt_req = 1'b0;
    step();
    pin_p("pt_quiet", 4'b0111);

    issue(1'b0, 10'h26C, 32'h0);
    bus.pt_req = 1'b1; bus.virtual_page_number = 6'd2;
    step();
    pin_p("ovl_vpn2", 4'b1110);
    bus.virtual_page_number = 6'd40;
    step();
    pin_p("ovl_vpn40", 4'b1000);
    bus.pt_req = 1'b0;
    wait_done(n);
    pin_d("ovl_read", {1'b1, 1'b1, 32'h0011_4514});
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
